// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between the fetch stage, the fetch queue
// and the decode stage. The queue connects through the slave modport; the
// fetch/decode side (or a bench standing in for it) uses the master modport.
interface fetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_pc;
  logic              out_ready;
  logic              flush;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction/PC buffer between fetch and decode.
// Valid/ready on both sides, single-cycle flush for taken branches, and an
// asynchronous active-low reset on rst.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a word straight
// from in_* to out_* when the queue is empty (zero-cycle latency).
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0] wp_reg;
  logic [PTR_W-1:0] rp_reg;
  logic [CNT_W-1:0] count_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // in_ready looks only at occupancy, never at out_ready, so a full queue
  // stays not-ready even when decode pops in the same cycle.
  assign bus.in_ready = ~full;
  assign bus.count    = count_reg;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  logic bypass_take;

  // An empty queue presents the incoming word directly; if decode takes it
  // this cycle it is never written into storage.
  assign bypass        = empty & bus.in_valid & ~bus.flush;
  assign bypass_take   = bypass & bus.out_ready;
  assign bus.out_valid = (~empty | bus.in_valid) & ~bus.flush;
  assign bus.out_instr = bypass ? bus.in_instr : instr_mem[rp_reg];
  assign bus.out_pc    = bypass ? bus.in_pc    : pc_mem[rp_reg];
  assign push          = bus.in_valid & ~full & ~bus.flush & ~bypass_take;
  // A bypassed word is not in storage, so the read pointer must not move.
  assign pop           = ~empty & ~bus.flush & bus.out_ready;
`else
  assign bus.out_valid = ~empty & ~bus.flush;
  assign bus.out_instr = instr_mem[rp_reg];
  assign bus.out_pc    = pc_mem[rp_reg];
  assign push          = bus.in_valid & ~full & ~bus.flush;
  assign pop           = bus.out_valid & bus.out_ready;
`endif

  // Storage write; contents are never reset or cleared by flush.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wp_reg] <= bus.in_instr;
      pc_mem[wp_reg]    <= bus.in_pc;
    end
  end

  // Pointer and occupancy update; flush overrides any push/pop that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else if (bus.flush) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        wp_reg <= wp_reg + PTR_W'(1);
      end
      if (pop) begin
        rp_reg <= rp_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue with a queue-based
// reference model checked every negative clock edge, plus literal checks
// for the fill/drain/stream/flush/reset/bypass scenarios.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DATA_W(32), .CNT_W(CNT_W)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(fq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents as {instr, pc} pairs.
  logic [63:0] model_q[$];
  // PCs that decode actually consumed, in order.
  logic [31:0] pop_log[$];

  // Model update on each clock edge from the inputs that were held there.
  always @(posedge clk) begin
    if (rst_n) begin
      if (fq.flush) begin
        model_q.delete();
      end else begin
        bit byp_take;
        bit do_pop;
        bit do_push;
        byp_take = BYP && model_q.size() == 0 && fq.in_valid && fq.out_ready;
        do_pop   = model_q.size() != 0 && fq.out_ready;
        do_push  = fq.in_valid && model_q.size() != DEPTH && !byp_take;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back({fq.in_instr, fq.in_pc});
      end
    end
  end

  // Reset discards everything immediately.
  always @(negedge rst_n) model_q.delete();

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    bit exp_valid;
    logic [63:0] head;
    exp_valid = (model_q.size() != 0 || (BYP && fq.in_valid && rst_n)) && !fq.flush;
    chk("count", 32'(fq.count), 32'(model_q.size()));
    chk("in_ready", 32'(fq.in_ready), 32'(model_q.size() != DEPTH));
    chk("out_valid", 32'(fq.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      head = (model_q.size() != 0) ? model_q[0] : {fq.in_instr, fq.in_pc};
      chk("out_instr", fq.out_instr, head[63:32]);
      chk("out_pc", fq.out_pc, head[31:0]);
    end
    if (fq.out_valid && fq.out_ready) pop_log.push_back(fq.out_pc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    fq.in_valid  = v;
    fq.in_pc     = pc;
    fq.in_instr  = 32'hC0DE_0000 ^ pc;
    fq.out_ready = rdy;
    fq.flush     = fl;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("reset_count", 32'(fq.count), 32'd0);
    chk("reset_in_ready", 32'(fq.in_ready), 32'd1);
    chk("reset_out_valid", 32'(fq.out_valid), 32'd0);
    step();
    rst_n = 1'b1;

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      step();
    end
    chk("fill_count", 32'(fq.count), 32'd4);
    chk("fill_in_ready", 32'(fq.in_ready), 32'd0);
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    step();
    chk("overflow_count", 32'(fq.count), 32'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      chk("drain_valid", 32'(fq.out_valid), 32'd1);
      chk("drain_pc", fq.out_pc, 32'(i * 4));
      step();
    end
    chk("drained_valid", 32'(fq.out_valid), 32'd0);
    chk("drained_count", 32'(fq.count), 32'd0);

    // Streaming with pointer wrap.
    pop_log.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
      step();
      chk("stream_count_le1", 32'(fq.count <= CNT_W'(BYP ? 0 : 1)), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk("stream_n", 32'(pop_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < pop_log.size(); i++)
      chk("stream_pc", pop_log[i], 32'h100 + 32'(i * 4));

    // Flush with a simultaneous push.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
      step();
    end
    chk("preflush_count", 32'(fq.count), 32'd3);
    pop_log.delete();
    drive(1'b1, 32'h200, 1'b0, 1'b1);
    #1;
    chk("flush_out_valid", 32'(fq.out_valid), 32'd0);
    step();
    chk("postflush_count", 32'(fq.count), 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h204, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    step();
    chk("postflush_n", 32'(pop_log.size()), 32'd1);
    if (pop_log.size() != 0) chk("postflush_pc", pop_log[0], 32'h204);

    // Asynchronous reset mid-stream.
    drive(1'b1, 32'h500, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h504, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("prereset_count", 32'(fq.count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(fq.count), 32'd0);
    chk("async_out_valid", 32'(fq.out_valid), 32'd0);
    chk("async_in_ready", 32'(fq.in_ready), 32'd1);
    step();
    rst_n = 1'b1;

    // Empty queue with a word arriving and decode ready.
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    #1;
    chk("byp_out_valid", 32'(fq.out_valid), 32'(BYP));
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_out_pc", fq.out_pc, 32'h40);
`endif
    step();
    chk("byp_count", 32'(fq.count), BYP ? 32'd0 : 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    step();
    chk("final_count", 32'(fq.count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
